// File: rtl/mdu_pkg.sv
// Shared MDU encodings: op codes, divider-controller FSM states, overflow MIN constants.
// The DRAIN state exists only when MDU_DIV_FLUSH_EN is defined.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3
`ifdef MDU_DIV_FLUSH_EN
    ,
    ST_DRAIN = 3'd4
`endif
  } div_state_e;

  localparam logic [31:0] MIN_W  = 32'h8000_0000;
  localparam logic [31:0] NEG1_W = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_special_detect.sv
// Combinational detection of divide-by-zero and signed overflow on prepared operands,
// producing the architecturally defined quotient/remainder so the Divider can be bypassed.
module div_special_detect
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            signed_i,
  input  logic            word_i,
  output logic            is_special_o,
  output logic [XLEN-1:0] spec_q_o,
  output logic [XLEN-1:0] spec_rem_o
);

  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

  logic div_zero;
  logic ovf_x;
  logic ovf_w;

  // Word operands arrive already extended, so the low half decides word overflow.
  assign div_zero = (divisor_i == '0);
  assign ovf_x    = signed_i & ~word_i & (dividend_i == MIN_X) & (divisor_i == '1);
  assign ovf_w    = signed_i & word_i & (dividend_i[31:0] == MIN_W) & (divisor_i[31:0] == NEG1_W);

  always_comb begin
    is_special_o = div_zero | ovf_x | ovf_w;
    spec_q_o     = '0;
    spec_rem_o   = '0;
    if (div_zero) begin
      spec_q_o   = '1;
      spec_rem_o = dividend_i;
    end else if (ovf_w) begin
      spec_q_o = {{(XLEN-32){1'b1}}, MIN_W};
    end else if (ovf_x) begin
      spec_q_o = MIN_X;
    end
  end

endmodule

// File: rtl/mdu_div_ctrl.sv
// Issue/retire controller between MDU dispatch and the multi-cycle Divider; special cases bypass it.
// Optional flush support (flush_i port, DRAIN state) is enabled by defining MDU_DIV_FLUSH_EN.
module mdu_div_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MIN_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
`ifdef MDU_DIV_FLUSH_EN
  input  logic            flush_i,
`endif
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      tag_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      tag_o,
  output logic            busy_o,
  output logic            div_start_o,
  output logic            div_sign_o,
  output logic [XLEN-1:0] div_dividend_o,
  output logic [XLEN-1:0] div_divisor_o,
  input  logic [XLEN-1:0] div_q_i,
  input  logic [XLEN-1:0] div_rem_i,
  input  logic            div_finish_i
);

  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(MIN_LAT - 1);

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            sign_q, sign_d;
  logic [4:0]      tag_q, tag_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] prep_a, prep_b;
  logic            is_special;
  logic [XLEN-1:0] spec_q, spec_rem;
  logic            lat_ok;
  logic            accept;

  function automatic logic [XLEN-1:0] prep(input logic [XLEN-1:0] v, input logic word,
                                           input logic sgn);
    if (!word) return v;
    return {{(XLEN-32){sgn & v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] wadj(input logic [XLEN-1:0] v, input logic word);
    if (!word) return v;
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  assign prep_a = prep(rs1_i, word_i, op_is_signed(op_i));
  assign prep_b = prep(rs2_i, word_i, op_is_signed(op_i));

  div_special_detect #(.XLEN(XLEN)) u_special (
    .dividend_i   (prep_a),
    .divisor_i    (prep_b),
    .signed_i     (op_is_signed(op_i)),
    .word_i       (word_i),
    .is_special_o (is_special),
    .spec_q_o     (spec_q),
    .spec_rem_o   (spec_rem)
  );

`ifdef MDU_DIV_FLUSH_EN
  assign in_ready_o = (state_q == ST_IDLE) & ~flush_i;
`else
  assign in_ready_o = (state_q == ST_IDLE);
`endif
  assign accept         = in_valid_i & in_ready_o;
  assign out_valid_o    = (state_q == ST_DONE);
  assign busy_o         = (state_q != ST_IDLE);
  assign div_start_o    = (state_q == ST_START);
  assign div_sign_o     = sign_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign result_o       = result_q;
  assign tag_o          = tag_q;
  // A finish seen before MIN_LAT cycles after start belongs to an older op.
  assign lat_ok         = (cnt_q >= CAP_CNT);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    word_d     = word_q;
    sign_d     = sign_q;
    tag_d      = tag_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d       = op_i;
          word_d     = word_i;
          sign_d     = op_is_signed(op_i);
          tag_d      = tag_i;
          dividend_d = prep_a;
          divisor_d  = prep_b;
          if (is_special) begin
            result_d = wadj(op_is_rem(op_i) ? spec_rem : spec_q, word_i);
            state_d  = ST_DONE;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_ok && div_finish_i) begin
          result_d = wadj(op_is_rem(op_q) ? div_rem_i : div_q_i, word_q);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
`ifdef MDU_DIV_FLUSH_EN
      ST_DRAIN: begin
        if (lat_ok && div_finish_i) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef MDU_DIV_FLUSH_EN
    if (flush_i) begin
      if (state_q == ST_START || state_q == ST_WAIT) begin
        result_d = result_q;
        state_d  = ST_DRAIN;
      end else if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      word_q     <= 1'b0;
      sign_q     <= 1'b0;
      tag_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      word_q     <= word_d;
      sign_q     <= sign_d;
      tag_q      <= tag_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Bench for mdu_div_ctrl: behavioural Divider with programmable latency/stale finish,
// RV64M reference model, directed corner cases then randomized ops.
module tb_mdu_div_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [1:0]  op_i = '0;
  logic        word_i = 1'b0;
  logic [63:0] rs1_i = '0;
  logic [63:0] rs2_i = '0;
  logic [4:0]  tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [63:0] result_o;
  logic [4:0]  tag_o;
  logic        busy_o;
  logic        div_start_o;
  logic        div_sign_o;
  logic [63:0] div_dividend_o;
  logic [63:0] div_divisor_o;
  logic [63:0] div_q_i = '0;
  logic [63:0] div_rem_i = '0;
  logic        div_finish_i = 1'b0;
`ifdef MDU_DIV_FLUSH_EN
  logic        flush_i = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;

  always #5 clk_i = ~clk_i;

  mdu_div_ctrl #(.XLEN(64), .MIN_LAT(2), .CNT_W(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
`ifdef MDU_DIV_FLUSH_EN
    .flush_i        (flush_i),
`endif
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .op_i           (op_i),
    .word_i         (word_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .tag_i          (tag_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .result_o       (result_o),
    .tag_o          (tag_o),
    .busy_o         (busy_o),
    .div_start_o    (div_start_o),
    .div_sign_o     (div_sign_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_q_i        (div_q_i),
    .div_rem_i      (div_rem_i),
    .div_finish_i   (div_finish_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural Divider: finish_o is a level held until the next start.
  function automatic logic [127:0] divide(input logic [63:0] a, input logic [63:0] b,
                                          input logic s);
    logic [63:0] q;
    logic [63:0] r;
    if (b == 64'd0) begin
      q = '1; r = a;
    end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a; r = '0;
    end else if (s) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  int          dv_lat = 2;
  logic        dv_stale = 1'b0;
  int          dv_cnt = 0;
  logic        dv_busy = 1'b0;
  logic [63:0] pend_q = '0;
  logic [63:0] pend_r = '0;

  always @(posedge clk_i) begin
    if (div_start_o) begin
      {pend_q, pend_r} <= divide(div_dividend_o, div_divisor_o, div_sign_o);
      dv_busy <= 1'b1;
      dv_cnt  <= 1;
      if (!dv_stale) div_finish_i <= 1'b0;
    end else if (dv_busy) begin
      if (dv_cnt >= dv_lat - 1) begin
        div_q_i      <= pend_q;
        div_rem_i    <= pend_r;
        div_finish_i <= 1'b1;
        dv_busy      <= 1'b0;
      end else begin
        div_finish_i <= 1'b0;
        dv_cnt       <= dv_cnt + 1;
      end
    end
  end

  always @(negedge clk_i) if (div_start_o) n_starts++;

  // RV64M reference straight from the ISA rules.
  function automatic logic [63:0] ref_div(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b,
                                          output logic spec);
    logic        sgn;
    logic [31:0] a32, b32, q32, r32, res32;
    logic [63:0] q, r;
    sgn = ~op[0];
    if (w) begin
      a32 = a[31:0]; b32 = b[31:0];
      spec = 1'b1;
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = '0;
      end else begin
        spec = 1'b0;
        if (sgn) begin
          q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
        end else begin
          q32 = a32 / b32; r32 = a32 % b32;
        end
      end
      res32 = op[1] ? r32 : q32;
      return {{32{res32[31]}}, res32};
    end
    spec = 1'b1;
    if (b == 64'd0) begin
      q = '1; r = a;
    end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a; r = '0;
    end else begin
      spec = 1'b0;
      if (sgn) begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end else begin
        q = a / b; r = a % b;
      end
    end
    return op[1] ? r : q;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input int hold);
    logic [63:0] exp;
    logic        spec;
    int          lat, exp_lat, s0, k;
    exp     = ref_div(op, w, a, b, spec);
    exp_lat = spec ? 1 : 2 + dv_lat;
    k = 0;
    while (!in_ready_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    check_eq("in_ready", 64'(in_ready_o), 64'd1);
    s0 = n_starts;
    in_valid_i = 1'b1; op_i = op; word_i = w; rs1_i = a; rs2_i = b; tag_i = tag;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 300) begin
      @(negedge clk_i);
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("result", result_o, exp);
    check_eq("tag", 64'(tag_o), 64'(tag));
    check_eq("starts", 64'(n_starts - s0), spec ? 64'd0 : 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      check_eq("hold", {out_valid_o, in_ready_o, 1'b0, tag_o, result_o[55:0]},
               {1'b1, 1'b0, 1'b0, tag, exp[55:0]});
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check_eq("release", 64'(out_valid_o), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check_eq("rst_ready", 64'(in_ready_o), 64'd1);
    check_eq("rst_ctl", {60'd0, out_valid_o, busy_o, div_start_o, div_sign_o}, 64'd0);
    check_eq("rst_result", result_o, 64'd0);
    check_eq("rst_tag", 64'(tag_o), 64'd0);
    check_eq("rst_dvd", div_dividend_o | div_divisor_o, 64'd0);

    dv_lat = 3;
    run_op(2'b00, 1'b0, -64'sd7, 64'd2, 5'd1, 0);
    run_op(2'b10, 1'b0, -64'sd7, 64'd2, 5'd2, 0);
    run_op(2'b01, 1'b0, 64'h10, 64'd0, 5'd3, 0);
    run_op(2'b11, 1'b0, 64'h10, 64'd0, 5'd4, 0);
    run_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd5, 0);
    run_op(2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd6, 0);
    run_op(2'b00, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF, 5'd7, 0);
    run_op(2'b11, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'd2, 5'd8, 0);
    dv_lat = 4;
    run_op(2'b01, 1'b0, 64'd1000, 64'd7, 5'd9, 5);

    // Previous finish still high through START and the first WAIT cycle.
    dv_stale = 1'b1;
    dv_lat = 2;
    run_op(2'b00, 1'b0, 64'd99, 64'd4, 5'd10, 0);
    dv_lat = 4;
    run_op(2'b11, 1'b0, 64'd77, 64'd10, 5'd11, 0);
    dv_stale = 1'b0;

    // Reset pulsed while waiting on the Divider.
    dv_lat = 8;
    in_valid_i = 1'b1; op_i = 2'b01; word_i = 1'b0; rs1_i = 64'd500; rs2_i = 64'd3; tag_i = 5'd12;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_eq("rst_mid", {61'd0, out_valid_o, in_ready_o, busy_o}, 64'd2);
    dv_lat = 3;
    run_op(2'b00, 1'b0, 64'd500, -64'sd3, 5'd13, 0);

`ifdef MDU_DIV_FLUSH_EN
    dv_lat = 6;
    in_valid_i = 1'b1; op_i = 2'b01; word_i = 1'b0; rs1_i = 64'd50; rs2_i = 64'd5; tag_i = 5'd14;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check_eq("drain", {62'd0, busy_o, in_ready_o}, 64'd2);
    begin
      int k;
      logic seen;
      k = 0; seen = 1'b0;
      while (!in_ready_o && k < 50) begin
        seen = seen | out_valid_o;
        @(negedge clk_i);
        k++;
      end
      check_eq("drain_end", {62'd0, seen, in_ready_o}, 64'd1);
    end
    run_op(2'b10, 1'b0, 64'd53, 64'd5, 5'd15, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic        w;
      logic [63:0] a, b;
      int          kind;
      op   = 2'($urandom);
      w    = 1'($urandom);
      kind = $urandom_range(0, 7);
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      if (kind == 0) begin
        b = w ? {32'($urandom), 32'h0} : 64'h0;
      end else if (kind == 1) begin
        a = w ? {32'($urandom), 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {32'($urandom), 32'hFFFF_FFFF} : '1;
      end else if (kind == 2) begin
        b = 64'($urandom_range(1, 9));
      end else if (kind == 3) begin
        b = -64'($urandom_range(1, 9));
      end
      dv_lat   = $urandom_range(2, 6);
      dv_stale = 1'($urandom);
      run_op(op, w, a, b, 5'(i), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
